fetch_align_buf: RTL and testbench
==================================

Name: fetch_align_buf

Overview:
Instruction fetch line buffer and aligner placed directly upstream of the RV32/RV16 expander in the fetch stage. It issues 8-byte-aligned ISRAM line requests, buffers the returned 64-bit lines, and extracts one instruction per cycle at halfword granularity. A 32-bit instruction that straddles two lines is assembled from both lines without a stall. Output is the raw instruction (16- or 32-bit) plus its PC; expansion of compressed instructions happens downstream.

Parameters:
DEPTH, 2, number of 64-bit line slots; in-flight requests plus buffered lines never exceed DEPTH (2..4)
RESET_PC, 32'h0000_0000, fetch address after reset; bits [2:1] give the initial halfword offset

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  redirect (branch/jump/trap); one-cycle pulse
flush_pc  in  32  redirect target; bit 0 ignored
req_valid  out  1  line request valid
req_addr  out  32  line address, bits [2:0] always 0
req_ready  in  1  ISRAM accepts request
rsp_valid  in  1  line data valid; responses return in request order, at least 1 cycle after acceptance
rsp_data  in  64  line data; halfword k = bits [16k+15:16k]
out_valid  out  1  instruction available
out_ready  in  1  consumer accepts instruction
out_pc  out  32  PC of out_instr
out_instr  out  32  raw instruction; upper 16 bits are zero when 16-bit
out_isrv16  out  1  out_instr[1:0] != 2'b11

Behaviour:
- State: fetch_addr[31:3], line FIFO (DEPTH x {base[31:3], data[63:0]}), line count lcnt, head halfword offset hoff[1:0], in-flight count pend, drop count drop.
- Reset: fetch_addr = RESET_PC[31:3]; hoff = RESET_PC[2:1]; lcnt = pend = drop = 0; out_valid = 0; req_valid evaluates to 1.
- Request: req_valid = !flush & (lcnt + pend < DEPTH). Credit freed by a pop in the same cycle is not reused in that cycle. On req_valid & req_ready: pend++ and fetch_addr += 1 (line granularity; wraps modulo 2^29).
- Response: each rsp_valid decrements pend.
  - If drop > 0: decrement drop and discard the data.
  - Otherwise: push {base, data}. The line base comes from a base-tracking copy of the request addresses held in order.
- Extraction: h0 = head line halfword hoff.
  - If h0[1:0] != 11: 16-bit instruction; out_valid = lcnt >= 1.
  - Otherwise, if hoff < 3: out_instr = head halfwords hoff+1:hoff; out_valid = lcnt >= 1.
  - Otherwise (hoff == 3): out_instr = {next line halfword 0, h0}; out_valid = lcnt >= 2.
- out_pc = {head base, hoff, 1'b0}.
- Consume on out_valid & out_ready: hoff advances by 1 (16-bit) or 2 (32-bit), modulo 4. On carry out of hoff, pop the head line. A straddling 32-bit instruction pops the head and leaves hoff = 1.
- A push and a pop in the same cycle are both performed; lcnt is unchanged.
- out_valid, out_pc and out_instr are combinational from registered state only. No path exists from out_ready or rsp_* to out_*.
- Flush has priority over every other event in that cycle:
  - the line FIFO is cleared (lcnt = 0); out_valid is 0 the following cycle;
  - fetch_addr = flush_pc[31:3]; hoff = flush_pc[2:1];
  - drop = pend + drop minus any response arriving that cycle (that response is also discarded);
  - no request is issued in the flush cycle; an out handshake in the flush cycle is ignored.
- Flush while drop > 0 accumulates the count correctly. Stale responses are never delivered.
- Reset asserted mid-operation clears all state immediately. Responses arriving after rst_n deasserts are not expected (ISRAM resets together with this block).
- Overflow is impossible by construction. A response arriving when lcnt + pend accounting does not permit it is a protocol violation; an assertion is required.

Test Plan:
- Reset, RESET_PC=0, req_ready=1, 1-cycle response, all 32-bit instructions -> req_addr 0x0, 0x8, ...; out_pc 0x0, 0x4, 0x8 on consecutive cycles; lines popped every 2 instructions.
- Line 0x0 halfwords {0x0001, 0x0001, 0x0001, 0x0013}, line 0x8 halfword0 = 0x0000 -> 16-bit at 0x0, 0x2, 0x4, then out_pc 0x6 with out_instr 0x0000_0013, out_valid only after line 0x8 arrives; hoff = 1 afterwards.
- out_ready=0 held -> lcnt reaches DEPTH, req_valid drops to 0; release -> the first request reissues only on the cycle after the first pop.
- Two requests in flight, flush with flush_pc=0x106 -> both stale responses discarded; next req_addr 0x100; first out_pc 0x106.
- Flush coincident with rsp_valid and a second flush 1 cycle later -> drop count correct; no stale instruction appears on out.
- req_ready=0 for 5 cycles -> req_valid and req_addr hold stable; out_valid stays 0; no spurious pend increment.

Source files
------------

// File: rtl/fetch_align_buf.sv
// Fetch line buffer and halfword aligner: requests 8-byte lines, buffers them,
// and presents one raw 16/32-bit instruction per cycle, including line-straddling ones.
module fetch_align_buf #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        req_valid,
  output logic [31:0] req_addr,
  input  logic        req_ready,
  input  logic        rsp_valid,
  input  logic [63:0] rsp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_isrv16
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int DW = 8;

  logic [28:0]   fetch_addr;
  logic [28:0]   rsp_base;
  logic [28:0]   line_base [DEPTH];
  logic [63:0]   line_data [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] lcnt;
  logic [CW-1:0] pend;
  logic [1:0]    hoff;
  logic [DW-1:0] drop;

  logic [63:0] head_line;
  logic [63:0] next_line;
  logic [15:0] h0;
  logic        is32;
  logic        straddle;
  logic        req_fire;
  logic        out_fire;
  logic        rsp_live;
  logic        pop;
  logic [2:0]  hsum;
  logic        unused_bits;

  function automatic logic [15:0] hw_sel(input logic [63:0] line, input logic [1:0] k);
    logic [15:0] h;
    case (k)
      2'd0:    h = line[15:0];
      2'd1:    h = line[31:16];
      2'd2:    h = line[47:32];
      default: h = line[63:48];
    endcase
    return h;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  assign unused_bits = flush_pc[0];

  assign head_line = line_data[rd_ptr];
  assign next_line = line_data[ptr_inc(rd_ptr)];
  assign h0        = hw_sel(head_line, hoff);
  assign is32      = (h0[1:0] == 2'b11);
  assign straddle  = is32 && (hoff == 2'b11);

  // Output view depends only on registered buffer state.
  always_comb begin
    out_instr = {16'h0000, h0};
    out_valid = (lcnt != '0);
    if (is32) begin
      if (straddle) begin
        out_instr = {hw_sel(next_line, 2'd0), h0};
        out_valid = (lcnt >= CW'(2));
      end else begin
        out_instr = {hw_sel(head_line, hoff + 2'd1), h0};
      end
    end
  end

  assign out_pc     = {line_base[rd_ptr], hoff, 1'b0};
  assign out_isrv16 = !is32;

  // Credit uses registered lcnt, so a slot freed by this cycle's pop is reused next cycle.
  assign req_valid = !flush && (({1'b0, lcnt} + {1'b0, pend}) < (CW + 1)'(DEPTH));
  assign req_addr  = {fetch_addr, 3'b000};

  assign req_fire = req_valid && req_ready;
  assign out_fire = out_valid && out_ready && !flush;
  assign rsp_live = rsp_valid && (drop == '0) && !flush;
  assign hsum     = {1'b0, hoff} + (is32 ? 3'd2 : 3'd1);
  assign pop      = out_fire && hsum[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_addr <= RESET_PC[31:3];
      rsp_base   <= RESET_PC[31:3];
      hoff       <= RESET_PC[2:1];
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      lcnt       <= '0;
      pend       <= '0;
      drop       <= '0;
    end else if (flush) begin
      fetch_addr <= flush_pc[31:3];
      rsp_base   <= flush_pc[31:3];
      hoff       <= flush_pc[2:1];
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      lcnt       <= '0;
      pend       <= '0;
      drop       <= drop + DW'(pend) - DW'(rsp_valid);
    end else begin
      if (req_fire) fetch_addr <= fetch_addr + 29'd1;
      if (rsp_live) begin
        wr_ptr   <= ptr_inc(wr_ptr);
        rsp_base <= rsp_base + 29'd1;
      end
      if (rsp_valid && (drop != '0)) drop <= drop - DW'(1);
      pend <= pend + CW'(req_fire) - CW'(rsp_live);
      lcnt <= lcnt + CW'(rsp_live) - CW'(pop);
      if (out_fire) hoff <= hsum[1:0];
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
    end
  end

  // Line storage carries no reset; occupancy is tracked by lcnt.
  always_ff @(posedge clk) begin
    if (rsp_live) begin
      line_base[wr_ptr] <= rsp_base;
      line_data[wr_ptr] <= rsp_data;
    end
  end

  rsp_expected: assert property (@(posedge clk) disable iff (!rst_n)
    rsp_valid |-> ((pend != '0) || (drop != '0)));

  rsp_has_room: assert property (@(posedge clk) disable iff (!rst_n)
    rsp_live |-> (lcnt < CW'(DEPTH)));

endmodule

// File: tb/tb_fetch_align_buf.sv
// Directed bench for fetch_align_buf with an in-order ISRAM responder of programmable latency.
module tb_fetch_align_buf;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [31:0] flush_pc;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        rsp_valid;
  logic [63:0] rsp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_isrv16;

  req_t        q[$];
  logic [31:0] acc_log[$];
  int          cyc = 0;
  int          lat = 1;
  bit          rsp_en = 1'b1;
  bit          prog_mode = 1'b0;
  int          errors = 0;
  int          checks = 0;

  fetch_align_buf #(.DEPTH(2), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .flush_pc(flush_pc),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instr(out_instr), .out_isrv16(out_isrv16)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

  // Memory image: halfword at pc; default halfwords all carry the 32-bit marker.
  function automatic logic [15:0] hw_at(input logic [31:0] pc);
    logic [13:0] m;
    if (prog_mode && pc < 32'h10) begin
      case (pc[3:1])
        3'd0, 3'd1, 3'd2: return 16'h0001;
        3'd3:             return 16'h0013;
        3'd4:             return 16'h0000;
        default:          ;
      endcase
    end
    m = pc[13:0] ^ (pc[1] ? 14'h2A5A : 14'h0000);
    return {m, 2'b11};
  endfunction

  function automatic logic [63:0] line_at(input logic [31:0] a);
    logic [63:0] d;
    for (int k = 0; k < 4; k++) d[16*k +: 16] = hw_at(a + 32'(2 * k));
    return d;
  endfunction

  function automatic logic [31:0] exp32(input logic [31:0] pc);
    return {hw_at(pc + 32'd2), hw_at(pc)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit          fire;
    logic [31:0] a;
    req_t        e;
    fire = rst_n && req_valid && req_ready;
    a    = req_addr;
    @(posedge clk);
    #1;
    cyc++;
    if (fire) begin
      e.addr = a;
      e.due  = cyc + lat - 1;
      q.push_back(e);
      acc_log.push_back(a);
    end
    flush = 1'b0;
    if (rsp_en && q.size() > 0 && q[0].due <= cyc) begin
      e         = q.pop_front();
      rsp_valid = 1'b1;
      rsp_data  = line_at(e.addr);
    end else begin
      rsp_valid = 1'b0;
      rsp_data  = '0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    flush     = 1'b0;
    flush_pc  = '0;
    rsp_valid = 1'b0;
    rsp_data  = '0;
    req_ready = 1'b1;
    out_ready = 1'b0;
    rsp_en    = 1'b1;
    lat       = 1;
    prog_mode = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_req_valid", 32'(req_valid), 32'd1);
    chk("rst_req_addr", req_addr, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    q.delete();
    acc_log.delete();
    rst_n = 1'b1;
  endtask

  task automatic wait_out(input string tag, input int max);
    int n = 0;
    while (!out_valid && n < max) begin
      tick();
      n++;
    end
    chk(tag, 32'(out_valid), 32'd1);
  endtask

  initial begin
    int n;

    // All 32-bit stream, single-cycle responses.
    do_reset();
    out_ready = 1'b1;
    wait_out("t1_first_valid", 20);
    for (int i = 0; i < 8; i++) begin
      chk("t1_valid", 32'(out_valid), 32'd1);
      chk("t1_pc", out_pc, 32'(4 * i));
      chk("t1_instr", out_instr, exp32(32'(4 * i)));
      tick();
    end
    for (int i = 0; i < 4; i++) chk("t1_req_addr", acc_log[i], 32'(8 * i));

    // Three compressed instructions, then one straddling into line 0x8.
    do_reset();
    prog_mode = 1'b1;
    out_ready = 1'b1;
    n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    chk("t2_first_rsp", 32'(rsp_valid), 32'd1);
    rsp_en = 1'b0;
    tick();
    chk("t2_v0", 32'(out_valid), 32'd1);
    chk("t2_pc0", out_pc, 32'h0);
    chk("t2_i0", out_instr, 32'h0000_0001);
    chk("t2_c0", 32'(out_isrv16), 32'd1);
    tick();
    chk("t2_pc2", out_pc, 32'h2);
    chk("t2_i2", out_instr, 32'h0000_0001);
    tick();
    chk("t2_pc4", out_pc, 32'h4);
    chk("t2_v4", 32'(out_valid), 32'd1);
    tick();
    chk("t2_wait_v", 32'(out_valid), 32'd0);
    chk("t2_wait_pc", out_pc, 32'h6);
    chk("t2_wait_req", 32'(req_valid), 32'd0);
    tick();
    chk("t2_wait_v2", 32'(out_valid), 32'd0);
    rsp_en = 1'b1;
    tick();
    chk("t2_wait_v3", 32'(out_valid), 32'd0);
    tick();
    chk("t2_v6", 32'(out_valid), 32'd1);
    chk("t2_pc6", out_pc, 32'h6);
    chk("t2_i6", out_instr, 32'h0000_0013);
    chk("t2_c6", 32'(out_isrv16), 32'd0);
    tick();
    chk("t2_va", 32'(out_valid), 32'd1);
    chk("t2_pca", out_pc, 32'hA);
    chk("t2_ia", out_instr, exp32(32'hA));

    // Consumer stall fills the buffer; credit returns only after the pop.
    do_reset();
    repeat (3) tick();
    chk("t3_full_req", 32'(req_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("t3_hold_req", 32'(req_valid), 32'd0);
      chk("t3_hold_pc", out_pc, 32'h0);
      tick();
    end
    out_ready = 1'b1;
    chk("t3_rel_req", 32'(req_valid), 32'd0);
    tick();
    chk("t3_pop_cycle_req", 32'(req_valid), 32'd0);
    chk("t3_pc4", out_pc, 32'h4);
    tick();
    chk("t3_reissue", 32'(req_valid), 32'd1);
    chk("t3_reissue_addr", req_addr, 32'h10);
    chk("t3_pc8", out_pc, 32'h8);

    // Flush with two requests in flight.
    do_reset();
    lat = 3;
    out_ready = 1'b1;
    tick();
    tick();
    chk("t4_inflight", 32'(acc_log.size()), 32'd2);
    flush    = 1'b1;
    flush_pc = 32'h106;
    #1;
    chk("t4_flush_noreq", 32'(req_valid), 32'd0);
    tick();
    chk("t4_req_valid", 32'(req_valid), 32'd1);
    chk("t4_req_addr", req_addr, 32'h100);
    wait_out("t4_out_timeout", 30);
    chk("t4_pc", out_pc, 32'h106);
    chk("t4_instr", out_instr, exp32(32'h106));
    chk("t4_acc", acc_log[2], 32'h100);

    // Flush coincident with a response, then a second flush the next cycle.
    do_reset();
    lat = 2;
    out_ready = 1'b1;
    tick();
    tick();
    chk("t5_rsp_at_flush", 32'(rsp_valid), 32'd1);
    flush    = 1'b1;
    flush_pc = 32'h40;
    tick();
    flush    = 1'b1;
    flush_pc = 32'h80;
    #1;
    chk("t5_flush2_noreq", 32'(req_valid), 32'd0);
    tick();
    chk("t5_req_addr", req_addr, 32'h80);
    wait_out("t5_out_timeout", 30);
    chk("t5_pc", out_pc, 32'h80);
    chk("t5_instr", out_instr, exp32(32'h80));

    // Request backpressure.
    do_reset();
    req_ready = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t6_req_valid", 32'(req_valid), 32'd1);
      chk("t6_req_addr", req_addr, 32'h0);
      chk("t6_out_valid", 32'(out_valid), 32'd0);
      tick();
    end
    req_ready = 1'b1;
    tick();
    chk("t6_after_req", 32'(req_valid), 32'd1);
    chk("t6_after_addr", req_addr, 32'h8);
    tick();
    chk("t6_credit", 32'(req_valid), 32'd0);
    chk("t6_out_valid_line", 32'(out_valid), 32'd1);
    chk("t6_out_pc", out_pc, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
